// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - ordered store checker with ignore window, timeout and sticky pass/fail
module store_monitor #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int N_EXP   = 4,
    parameter int TIMEOUT = 10000,
    localparam int IDX_W  = (N_EXP > 1) ? $clog2(N_EXP) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_adr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [ADDR_W-1:0] ign_base,
    input  logic [ADDR_W-1:0] ign_mask,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [4:0]        match_cnt,
    output logic [ADDR_W-1:0] fail_adr,
    output logic [DATA_W-1:0] fail_data,
    output logic [23:0]       cycle_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASSED, S_FAILED} stateType;

    localparam int             TBL_N       = 1 << IDX_W;
    localparam logic [IDX_W:0] N_EXP_IDX   = (IDX_W + 1)'(N_EXP);
    localparam logic [4:0]     N_EXP_CNT   = 5'(N_EXP);
    localparam logic [23:0]    TIMEOUT_CNT = 24'(TIMEOUT);
    localparam logic [1:0]     CODE_NONE   = 2'b00;
    localparam logic [1:0]     CODE_ADR    = 2'b01;
    localparam logic [1:0]     CODE_DATA   = 2'b10;
    localparam logic [1:0]     CODE_TMO    = 2'b11;

    stateType          state, stateNext;
    logic [4:0]        matchCnt, matchNext, matchInc;
    logic [23:0]       cycleCnt, cycleNext;
    logic [1:0]        failCode, codeNext;
    logic [ADDR_W-1:0] failAdr, failAdrNext;
    logic [DATA_W-1:0] failData, failDataNext;
    logic              tableWe, runEnded, storeIgnored;
    logic [ADDR_W-1:0] curAdr;
    logic [DATA_W-1:0] curData;

    // Table is deliberately left out of reset; software reprograms it after reset.
    logic [ADDR_W-1:0] expAdr  [TBL_N];
    logic [DATA_W-1:0] expData [TBL_N];

    assign storeIgnored = (ign_mask != '0) && ((data_adr & ign_mask) == (ign_base & ign_mask));
    assign curAdr       = expAdr[matchCnt[IDX_W-1:0]];
    assign curData      = expData[matchCnt[IDX_W-1:0]];
    assign matchInc     = (matchCnt == 5'd31) ? matchCnt : matchCnt + 5'd1;

    always_comb begin
        stateNext    = state;
        matchNext    = matchCnt;
        cycleNext    = cycleCnt;
        codeNext     = failCode;
        failAdrNext  = failAdr;
        failDataNext = failData;
        tableWe      = 1'b0;
        runEnded     = 1'b0;
        unique case (state)
            S_IDLE: begin
                tableWe = cfg_we && ({1'b0, cfg_idx} < N_EXP_IDX);
                if (start) begin
                    stateNext    = S_ARMED;
                    matchNext    = '0;
                    cycleNext    = '0;
                    codeNext     = CODE_NONE;
                    failAdrNext  = '0;
                    failDataNext = '0;
                end
            end
            S_ARMED: begin
                cycleNext = (cycleCnt == '1) ? cycleCnt : cycleCnt + 24'd1;
                if (mem_write && !storeIgnored) begin
                    if (data_adr != curAdr) begin
                        stateNext    = S_FAILED;
                        codeNext     = CODE_ADR;
                        failAdrNext  = data_adr;
                        failDataNext = write_data;
                        runEnded     = 1'b1;
                    end else if (write_data != curData) begin
                        stateNext    = S_FAILED;
                        codeNext     = CODE_DATA;
                        failAdrNext  = data_adr;
                        failDataNext = write_data;
                        runEnded     = 1'b1;
                    end else begin
                        matchNext = matchInc;
                        if (matchInc == N_EXP_CNT) begin
                            stateNext = S_PASSED;
                            runEnded  = 1'b1;
                        end
                    end
                end
                // A store that ends the run on the timeout cycle takes precedence.
                if (!runEnded && cycleNext >= TIMEOUT_CNT) begin
                    stateNext = S_FAILED;
                    codeNext  = CODE_TMO;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            matchCnt <= '0;
            cycleCnt <= '0;
            failCode <= CODE_NONE;
            failAdr  <= '0;
            failData <= '0;
        end else begin
            state    <= stateNext;
            matchCnt <= matchNext;
            cycleCnt <= cycleNext;
            failCode <= codeNext;
            failAdr  <= failAdrNext;
            failData <= failDataNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && tableWe) begin
            expAdr[cfg_idx]  <= cfg_adr;
            expData[cfg_idx] <= cfg_data;
        end
    end

    assign busy      = (state == S_ARMED);
    assign pass      = (state == S_PASSED);
    assign fail      = (state == S_FAILED);
    assign fail_code = failCode;
    assign match_cnt = matchCnt;
    assign cycle_cnt = cycleCnt;
    assign fail_adr  = failAdr;
    assign fail_data = failData;

endmodule

// File: tb/tb_store_monitor.sv
// tb/tb_store_monitor.sv - directed and randomized checks of store_monitor against a queue-based model
module tb_store_monitor;

    localparam int NE = 3;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_adr = '0;
    logic [31:0] cfg_data = '0;
    logic [31:0] ign_base = '0;
    logic [31:0] ign_mask = '0;
    logic        start = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_adr = '0;
    logic [31:0] write_data = '0;
    logic        busy, pass, fail;
    logic [1:0]  fail_code;
    logic [4:0]  match_cnt;
    logic [31:0] fail_adr, fail_data;
    logic [23:0] cycle_cnt;

    always #5 clk = ~clk;

    store_monitor #(.DATA_W(32), .ADDR_W(32), .N_EXP(NE), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
        .cfg_data(cfg_data), .ign_base(ign_base), .ign_mask(ign_mask), .start(start),
        .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data), .busy(busy),
        .pass(pass), .fail(fail), .fail_code(fail_code), .match_cnt(match_cnt),
        .fail_adr(fail_adr), .fail_data(fail_data), .cycle_cnt(cycle_cnt)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model: the run is a queue of outstanding expected stores snapshotted at start.
    typedef struct packed { logic [31:0] adr; logic [31:0] data; } storeT;
    logic [31:0] tblAdr [4];
    logic [31:0] tblData [4];
    storeT       pendQ[$];
    string       mPhase = "idle";
    int          mMatch = 0, mCycles = 0, mCode = 0;
    logic [31:0] mFa = '0, mFd = '0;

    function automatic bit inWindow(input logic [31:0] a);
        return (ign_mask != 0) && (((a ^ ign_base) & ign_mask) == 0);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            mPhase = "idle"; mMatch = 0; mCycles = 0; mCode = 0; mFa = '0; mFd = '0;
            pendQ.delete();
        end else if (mPhase == "idle") begin
            if (cfg_we && cfg_idx < NE) begin
                tblAdr[cfg_idx] = cfg_adr;
                tblData[cfg_idx] = cfg_data;
            end
            if (start) begin
                mPhase = "armed"; mMatch = 0; mCycles = 0; mCode = 0; mFa = '0; mFd = '0;
                pendQ.delete();
                for (int i = 0; i < NE; i++) pendQ.push_back({tblAdr[i], tblData[i]});
            end
        end else if (mPhase == "armed") begin
            mCycles++;
            if (mem_write && !inWindow(data_adr)) begin
                if (data_adr != pendQ[0].adr || write_data != pendQ[0].data) begin
                    mPhase = "fail";
                    mCode = (data_adr != pendQ[0].adr) ? 1 : 2;
                    mFa = data_adr;
                    mFd = write_data;
                end else begin
                    void'(pendQ.pop_front());
                    mMatch++;
                    if (pendQ.size() == 0) mPhase = "pass";
                end
            end
            if (mPhase == "armed" && mCycles == TO) begin
                mPhase = "fail";
                mCode = 3;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("busy", busy, mPhase == "armed");
            chk("pass", pass, mPhase == "pass");
            chk("fail", fail, mPhase == "fail");
            chk("fail_code", fail_code, mCode);
            chk("match_cnt", match_cnt, mMatch);
            chk("cycle_cnt", cycle_cnt, mCycles);
            chk("fail_adr", fail_adr, mFa);
            chk("fail_data", fail_data, mFd);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        cfg_we = 1'b0; start = 1'b0; mem_write = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_adr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1; data_adr = a; write_data = d;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    storeT nx;
    int    r;

    initial begin
        ign_base = 32'd96;
        ign_mask = 32'hFFFF_FFFF;
        doReset();
        chk("rst_busy", busy, 0); chk("rst_pass", pass, 0); chk("rst_fail", fail, 0);
        chk("rst_code", fail_code, 0); chk("rst_match", match_cnt, 0); chk("rst_cycle", cycle_cnt, 0);

        cfg(0, 100, 7); cfg(1, 104, 9); cfg(2, 108, 11);
        go();
        store(96, 3);
        chk("ign_match", match_cnt, 0); chk("ign_busy", busy, 1);
        store(100, 7); store(104, 9); store(108, 11);
        chk("seq_pass", pass, 1); chk("seq_match", match_cnt, 3);
        chk("seq_code", fail_code, 0); chk("seq_cycle", cycle_cnt, 4);

        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_adr = 200; cfg_data = 1;
        start = 1'b1; mem_write = 1'b1; data_adr = 5; write_data = 5;
        tick();
        idleInputs();
        chk("sticky_pass", pass, 1); chk("sticky_fail", fail, 0);
        chk("sticky_match", match_cnt, 3); chk("sticky_cycle", cycle_cnt, 4);
        doReset(); go();
        store(100, 7); store(104, 9); store(108, 11);
        chk("table_kept", pass, 1);

        doReset(); go();
        store(100, 7); store(108, 9);
        chk("adr_fail", fail, 1); chk("adr_code", fail_code, 1);
        chk("adr_fadr", fail_adr, 108); chk("adr_fdata", fail_data, 9); chk("adr_match", match_cnt, 1);

        doReset(); go();
        store(100, 8);
        chk("data_fail", fail, 1); chk("data_code", fail_code, 2);
        chk("data_fdata", fail_data, 8); chk("data_fadr", fail_adr, 100);

        doReset(); go();
        repeat (19) tick();
        chk("tmo_busy19", busy, 1); chk("tmo_cycle19", cycle_cnt, 19);
        tick();
        chk("tmo_fail", fail, 1); chk("tmo_code", fail_code, 3);
        chk("tmo_cycle", cycle_cnt, 20); chk("tmo_fadr", fail_adr, 0);
        repeat (3) tick();
        chk("tmo_frozen", cycle_cnt, 20);

        doReset(); go();
        store(100, 7); store(104, 9);
        repeat (17) tick();
        store(108, 11);
        chk("last_pass", pass, 1); chk("last_code", fail_code, 0); chk("last_cycle", cycle_cnt, 20);

        doReset(); go();
        store(100, 7);
        chk("abort_match1", match_cnt, 1);
        reset = 1'b0; start = 1'b1; mem_write = 1'b1; data_adr = 104; write_data = 9;
        tick();
        reset = 1'b1; idleInputs();
        chk("abort_busy", busy, 0); chk("abort_match", match_cnt, 0); chk("abort_cycle", cycle_cnt, 0);
        repeat (3) tick();
        chk("abort_pass", pass, 0); chk("abort_fail", fail, 0);

        for (int run = 0; run < 80; run++) begin
            doReset();
            r = $urandom_range(0, 2);
            ign_mask = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : 32'hFFFF_FFF0;
            ign_base = 32'h100 + 4 * $urandom_range(0, 7);
            if ($urandom_range(0, 2) != 0) begin
                for (int i = 0; i < 4; i++) begin
                    cfg_we = 1'b1; cfg_idx = i[1:0];
                    cfg_adr = 32'h100 + 4 * $urandom_range(0, 7);
                    cfg_data = $urandom_range(0, 3);
                    start = (i == 3) && ($urandom_range(0, 1) == 1);
                    tick();
                end
                idleInputs();
            end
            if (mPhase == "idle") go();
            for (int k = 0; k < 26; k++) begin
                if (pendQ.size() > 0) nx = pendQ[0];
                else nx = {32'h100, 32'h0};
                r = $urandom_range(0, 11);
                mem_write = (r <= 7);
                data_adr = nx.adr;
                write_data = nx.data;
                if (r == 5) begin
                    data_adr = ign_base | $urandom_range(0, 15);
                    write_data = $urandom;
                end else if (r == 6) begin
                    data_adr = nx.adr ^ (32'h4 << $urandom_range(0, 3));
                end else if (r == 7) begin
                    write_data = nx.data ^ (32'h1 << $urandom_range(0, 31));
                end
                cfg_we = ($urandom_range(0, 7) == 0);
                cfg_idx = 2'($urandom_range(0, 3));
                cfg_adr = 32'h100 + 4 * $urandom_range(0, 7);
                cfg_data = $urandom_range(0, 3);
                start = ($urandom_range(0, 7) == 0);
                reset = ($urandom_range(0, 39) != 0);
                tick();
            end
            idleInputs();
            reset = 1'b1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter DATA_W, default 32, width of store data and expected data.
REQ-002 Parameter ADDR_W, default 32, width of store address and expected address.
REQ-003 Parameter N_EXP, default 4, number of expected stores in the ordered check table; legal range 1..16.
REQ-004 Parameter TIMEOUT, default 10000, cycles in ARMED before timeout fail; legal range 1..2^24-1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-007 cfg_we  input  1  write one check-table entry; honoured only in IDLE.
REQ-008 cfg_idx  input  $clog2(N_EXP) (min 1)  table entry index.
REQ-009 cfg_adr  input  ADDR_W  expected address for entry.
REQ-010 cfg_data  input  DATA_W  expected data for entry.
REQ-011 ign_base  input  ADDR_W  base of ignored (scratch) address window.
REQ-012 ign_mask  input  ADDR_W  window mask; store ignored when (data_adr & ign_mask) == (ign_base & ign_mask) and ign_mask != 0.
REQ-013 start  input  1  single-cycle pulse; IDLE -> ARMED.
REQ-014 mem_write  input  1  store strobe from processor data port.
REQ-015 data_adr  input  ADDR_W  store address.
REQ-016 write_data  input  DATA_W  store data.
REQ-017 busy  output  1  high in ARMED.
REQ-018 pass  output  1  high in PASS.
REQ-019 fail  output  1  high in FAIL.
REQ-020 fail_code  output  2  00 none, 01 address mismatch, 10 data mismatch, 11 timeout.
REQ-021 match_cnt  output  5  expected entries matched so far.
REQ-022 fail_adr / fail_data  output  ADDR_W / DATA_W  captured offending store; zero for timeout.
REQ-023 cycle_cnt  output  24  cycles spent in ARMED; freezes in PASS/FAIL.

Function
REQ-024 FSM states IDLE, ARMED, PASS, FAIL; exactly one active.
REQ-025 IDLE: cfg_we writes table[cfg_idx] in one cycle; cfg_idx >= N_EXP ignored; start -> ARMED, clears match_cnt, cycle_cnt, fail_code, fail_adr, fail_data.
REQ-026 start and cfg_we in same IDLE cycle: write performed, then ARMED next cycle.
REQ-027 ARMED: store sampled when mem_write=1 at rising edge; one store per cycle max.
REQ-028 Ignored-window store: no effect on match_cnt or state.
REQ-029 Non-ignored store: compared to table[match_cnt]; address and data equal -> match_cnt+1.
REQ-030 Match raising match_cnt to N_EXP -> PASS next cycle.
REQ-031 Address differs -> FAIL, code 01; address equal, data differs -> FAIL, code 10; offending store captured in fail_adr/fail_data.
REQ-032 cycle_cnt increments each ARMED cycle; reaching TIMEOUT with no store evaluated that cycle -> FAIL, code 11.
REQ-033 Store and timeout same cycle: store evaluated first; timeout only if store did not end the run.
REQ-034 Latency: status outputs registered, valid the cycle after deciding edge.
REQ-035 PASS/FAIL sticky; mem_write, cfg_we, start ignored; exit only via reset.
REQ-036 start outside IDLE ignored.
REQ-037 Comparisons use full ADDR_W/DATA_W, no X-propagation masking; counters saturate, never wrap.

Reset
REQ-038 reset=0 at rising edge: state IDLE; busy, pass, fail 0; fail_code 00; match_cnt, cycle_cnt, fail_adr, fail_data 0.
REQ-039 Table contents not reset; reconfigure after reset.
REQ-040 Reset mid-ARMED aborts run with no pass/fail pulse; reset dominates all inputs that cycle.

Verification
REQ-041 Load entry0=(100,7), N_EXP=1, ign window 96/mask all-ones, start; stores (96,3),(100,7) -> pass=1, match_cnt=1, fail_code=00.
REQ-042 N_EXP=2 table (100,7),(104,9); stores (100,7),(108,9) -> fail=1, fail_code=01, fail_adr=108, fail_data=9, match_cnt=1.
REQ-043 Table (100,7); store (100,8) -> fail=1, fail_code=10, fail_data=8.
REQ-044 TIMEOUT=20, start, no stores -> fail=1, fail_code=11, cycle_cnt=20; store at cycle 20 matching -> pass instead.
REQ-045 Reset low for one cycle while ARMED with match_cnt=1 -> next cycle IDLE, all outputs 0, no pass/fail.
REQ-046 In PASS, cfg_we plus start plus non-matching store -> outputs unchanged, table unchanged.
